neighbor_count_scanner: RTL

Sequential, parametrised successor to the combinational 3x3 ones-counter. It latches a whole ROWS x COLS occupancy board on a start pulse. It then streams, one cell per accepted transfer in row-major order, the number of set cells in each cell's 3x3 neighbourhood, and finishes with a done pulse and a board-wide total. It sits between the board storage and the display/BCD path, replacing per-cell instances of the fixed 9-bit counter.

---
 rtl/neighbor_count_scanner_if.sv | 31 +++
 rtl/neighbor_count_scanner.sv | 117 +++++++++++
 2 files changed

// File: rtl/neighbor_count_scanner_if.sv
// Handshake and board bus between the scanner and its board source / result consumer.
// master is the scanner side; slave is the board source / result consumer side.
interface neighbor_count_scanner_if #(
  parameter int unsigned ROWS = 10,
  parameter int unsigned COLS = 10
);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned TW = $clog2(ROWS * COLS + 1);

  logic [ROWS*COLS-1:0] Board;
  logic                 Start;
  logic                 Busy;
  logic                 Valid;
  logic                 Ready;
  logic [RW-1:0]        Row;
  logic [CW-1:0]        Col;
  logic [3:0]           Count;
  logic                 Done;
  logic [TW-1:0]        Total;

  modport master (
    input  Board, Start, Ready,
    output Busy, Valid, Row, Col, Count, Done, Total
  );

  modport slave (
    output Board, Start, Ready,
    input  Busy, Valid, Row, Col, Count, Done, Total
  );
endinterface

// File: rtl/neighbor_count_scanner.sv
// Latches an occupancy board and streams each cell's 3x3 neighbourhood popcount
// in row-major order, then pulses Done with the board-wide set-cell total.
module neighbor_count_scanner #(
  parameter int unsigned ROWS           = 10,
  parameter int unsigned COLS           = 10,
  parameter bit          INCLUDE_CENTER = 1'b1
) (
  input logic                      clock,
  input logic                      reset_L,
  neighbor_count_scanner_if.master bus
);
  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int unsigned TW    = $clog2(CELLS + 1);

  localparam logic [RW-1:0] LastRow = RW'(ROWS - 1);
  localparam logic [CW-1:0] LastCol = CW'(COLS - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           state_q, state_d;
  logic [CELLS-1:0] snap_q, snap_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [TW-1:0]    total_q, total_d;
  logic [3:0]       win_cnt;
  logic [IW-1:0]    cur_idx;
  logic [IW-1:0]    win_idx;
  int               rr, cc;

  // State, snapshot, indices and running total; reset clears everything.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= StIdle;
      snap_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      total_q <= total_d;
    end
  end

  // Popcount of the snapshot over the 3x3 window around (row_q, col_q); off-board is 0.
  always_comb begin
    win_cnt = '0;
    rr      = 0;
    cc      = 0;
    win_idx = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr      = int'(row_q) + dr;
        cc      = int'(col_q) + dc;
        win_idx = IW'(rr * int'(COLS) + cc);
        if (rr >= 0 && rr < int'(ROWS) && cc >= 0 && cc < int'(COLS) &&
            (INCLUDE_CENTER || dr != 0 || dc != 0)) begin
          win_cnt = win_cnt + {3'b000, snap_q[win_idx]};
        end
      end
    end
  end

  // Next state: latch on Start in idle, advance row-major on each accepted transfer.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    row_d   = row_q;
    col_d   = col_q;
    total_d = total_q;
    cur_idx = IW'(int'(row_q) * int'(COLS) + int'(col_q));
    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          snap_d  = bus.Board;
          row_d   = '0;
          col_d   = '0;
          total_d = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (bus.Ready) begin
          total_d = total_q + TW'(snap_q[cur_idx]);
          if (col_q == LastCol) begin
            col_d = '0;
            if (row_q == LastRow) begin
              // Indices park at 0 so idle outputs read as zero.
              row_d   = '0;
              state_d = StDone;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs come only from registered state, so Ready never reaches them combinationally.
  assign bus.Busy  = (state_q != StIdle);
  assign bus.Valid = (state_q == StScan);
  assign bus.Done  = (state_q == StDone);
  assign bus.Row   = row_q;
  assign bus.Col   = col_q;
  assign bus.Count = (state_q == StScan) ? win_cnt : 4'd0;
  assign bus.Total = total_q;
endmodule
